// File: rtl/varwidth_fifo_withpre.sv
// Pre/post-trigger sample capture buffer with 10-bit to byte readout.
// Holds a window of pre-trigger history, fills after trigger, then streams.
module varwidth_fifo_withpre #(
  parameter int number_samples = 100
) (
  input  logic        wr_clk,
  input  logic        rst,
  input  logic [9:0]  wr_data,
  input  logic        wr_ce,
  input  logic [31:0] wr_circular_depth,
  input  logic        wr_trigger,
  output logic        wr_full,
  output logic [7:0]  rd_data,
  input  logic        rd_ce,
  input  logic        rd_clk
);

  localparam int N  = number_samples;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);
  localparam int B  = N * 10 / 8;
  localparam int BW = $clog2(B + 1);

  typedef enum logic [1:0] {PRE, POST, DONE} state_t;

  state_t        state;
  logic [9:0]    mem [N];
  logic [AW-1:0] wp;
  logic [AW-1:0] start;
  logic [CW-1:0] count;
  logic [CW-1:0] d;
  logic [AW-1:0] start_win;
  logic          we;

  logic [AW-1:0] rd_ptr;
  logic [2:0]    rd_pos;
  logic [BW-1:0] rd_idx;
  logic [AW-1:0] nptr;
  logic [2:0]    npos;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic [19:0]   cat;
  logic [4:0]    sh;
  logic [7:0]    nbyte;

  // rd_clk shares the wr_clk source and is not used internally
  logic unused_rd_clk;
  assign unused_rd_clk = rd_clk;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] a);
    return (a == AW'(N - 1)) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [AW-1:0] addr(
    input logic [AW-1:0] p,
    input int            off
  );
    int t;
    t = int'(p) + off;
    if (t >= N) t = t - N;
    return AW'(t);
  endfunction

  // effective pre-trigger depth and the window start it implies
  always_comb begin
    int s;
    d = (wr_circular_depth > 32'(N - 1))
      ? CW'(N - 1) : wr_circular_depth[CW-1:0];
    s = int'(wp) + 1 + N - int'(d);
    if (s >= N) s = s - N;
    if (s >= N) s = s - N;
    start_win = AW'(s);
  end

  assign we = !rst && wr_ce && (state != DONE);

  // sample storage, contents survive reset
  always_ff @(posedge wr_clk) begin
    if (we) mem[wp] <= wr_data;
  end

  // next readout byte: two adjacent samples, window picked by position
  always_comb begin
    npos   = (rd_pos == 3'd4) ? 3'd0 : rd_pos + 3'd1;
    nptr   = (rd_pos == 3'd4) ? addr(rd_ptr, 4) : rd_ptr;
    a_addr = addr(nptr, (npos == 3'd0) ? 0 : int'(npos) - 1);
    b_addr = addr(nptr, (npos == 3'd4) ? 3 : int'(npos));
    cat    = {mem[a_addr], mem[b_addr]};
    sh     = {1'b0, npos, 1'b0} + 5'd2;
    nbyte  = 8'(cat >> sh);
  end

  // capture FSM and byte packer
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state   <= PRE;
      wp      <= '0;
      start   <= '0;
      count   <= '0;
      wr_full <= 1'b0;
      rd_data <= 8'h00;
      rd_ptr  <= '0;
      rd_pos  <= '0;
      rd_idx  <= '0;
    end else begin
      unique case (state)
        PRE: begin
          if (wr_trigger) begin
            state <= POST;
            if (wr_ce) begin
              wp    <= inc(wp);
              count <= count + 1'b1;
              if (count == CW'(N - 1)) begin
                state   <= DONE;
                wr_full <= 1'b1;
                rd_data <= mem[start][9:2];
                rd_ptr  <= start;
              end
            end
          end else if (wr_ce) begin
            wp <= inc(wp);
            if (count < d) begin
              count <= count + 1'b1;
            end else begin
              count <= d;
              start <= start_win;
            end
          end
        end
        POST: begin
          if (wr_ce) begin
            wp    <= inc(wp);
            count <= count + 1'b1;
            if (count == CW'(N - 1)) begin
              state   <= DONE;
              wr_full <= 1'b1;
              rd_data <= mem[start][9:2];
              rd_ptr  <= start;
            end
          end
        end
        default: begin
          if (rd_ce && (rd_idx < BW'(B))) begin
            rd_idx  <= rd_idx + 1'b1;
            rd_ptr  <= nptr;
            rd_pos  <= npos;
            rd_data <= (rd_idx == BW'(B - 1)) ? 8'h00 : nbyte;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_varwidth_fifo_withpre.sv
// Directed bench for varwidth_fifo_withpre.
// Vector table plus capture/readout sequences against a queue model.
module tb_varwidth_fifo_withpre;

  localparam int N = 100;
  localparam int B = 125;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  wr_data;
  logic        wr_ce;
  logic [31:0] wr_circular_depth;
  logic        wr_trigger;
  logic        wr_full;
  logic [7:0]  rd_data;
  logic        rd_ce;

  always #5 clk = ~clk;

  varwidth_fifo_withpre #(.number_samples(N)) dut (
    .wr_clk            (clk),
    .rst               (rst),
    .wr_data           (wr_data),
    .wr_ce             (wr_ce),
    .wr_circular_depth (wr_circular_depth),
    .wr_trigger        (wr_trigger),
    .wr_full           (wr_full),
    .rd_data           (rd_data),
    .rd_ce             (rd_ce),
    .rd_clk            (clk)
  );

  typedef struct {
    logic        rst;
    logic        ce;
    logic        trig;
    logic        rdce;
    logic [9:0]  data;
    logic [31:0] depth;
    logic        exp_full;
    logic [7:0]  exp_rd;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  int q[$];
  int mstate = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    mstate = 0;
  endtask

  task automatic m_write(input int data, input bit ce, input bit trig,
                         input int depth);
    int dd;
    dd = (depth > N - 1) ? N - 1 : depth;
    if (mstate == 0) begin
      if (trig) begin
        mstate = 1;
        if (ce) begin
          q.push_back(data);
          if (q.size() == N) mstate = 2;
        end
      end else if (ce) begin
        q.push_back(data);
        while (q.size() > dd) void'(q.pop_front());
      end
    end else if (mstate == 1 && ce) begin
      q.push_back(data);
      if (q.size() == N) mstate = 2;
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    logic [7:0] r;
    int j;
    int s;
    r = 8'h00;
    for (int b = 0; b < 8; b++) begin
      j = 8 * k + b;
      s = q[j / 10];
      r[7 - b] = s[9 - (j % 10)];
    end
    return r;
  endfunction

  task automatic step(input bit r, input bit ce, input int data,
                      input bit trig, input int depth, input bit rdce);
    rst = r;
    wr_ce = ce;
    wr_data = 10'(data);
    wr_trigger = trig;
    wr_circular_depth = 32'(depth);
    rd_ce = rdce;
    if (r) m_reset();
    else if (mstate != 2) m_write(data, ce, trig, depth);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cap(input string name);
    chk({name, "_full"}, int'(wr_full), (mstate == 2) ? 1 : 0);
    if (mstate != 2) chk({name, "_rd"}, int'(rd_data), 0);
  endtask

  task automatic read_all(input int depth, input string name);
    step(0, 0, 0, 0, depth, 0);
    step(0, 0, 0, 0, depth, 0);
    chk({name, "_b0"}, int'(rd_data), int'(exp_byte(0)));
    for (int k = 1; k < B; k++) begin
      step(0, 0, 0, 0, depth, 1);
      chk({name, "_byte"}, int'(rd_data), int'(exp_byte(k)));
    end
    step(0, 0, 0, 0, depth, 1);
    chk({name, "_end"}, int'(rd_data), 0);
    step(0, 0, 0, 0, depth, 1);
    chk({name, "_end2"}, int'(rd_data), 0);
    chk({name, "_full_end"}, int'(wr_full), 1);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1, 1, 1, 1, 10'd5,  2, 0, 8'h00};
    tbl[1] = '{0, 0, 0, 1, 10'd0,  2, 0, 8'h00};
    tbl[2] = '{0, 1, 0, 1, 10'd10, 2, 0, 8'h00};
    tbl[3] = '{0, 1, 0, 0, 10'd11, 2, 0, 8'h00};
    tbl[4] = '{0, 1, 0, 0, 10'd12, 2, 0, 8'h00};
    tbl[5] = '{0, 1, 1, 0, 10'd13, 2, 0, 8'h00};
    tbl[6] = '{0, 1, 1, 1, 10'd14, 2, 0, 8'h00};

    rst = 1'b1;
    wr_ce = 1'b0;
    wr_data = '0;
    wr_trigger = 1'b0;
    wr_circular_depth = '0;
    rd_ce = 1'b0;

    // D=2 table: reset priority, rd_ce before full, trigger write
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].rst, tbl[i].ce, int'(tbl[i].data), tbl[i].trig,
           int'(tbl[i].depth), tbl[i].rdce);
      chk($sformatf("tbl%0d_full", i), int'(wr_full), int'(tbl[i].exp_full));
      chk($sformatf("tbl%0d_rd", i), int'(rd_data), int'(tbl[i].exp_rd));
    end
    for (int i = 0; i < 96; i++) begin
      step(0, 1, 20 + i, 0, 2, 0);
      chk_cap("d2_fill");
    end
    chk("d2_full", int'(wr_full), 1);
    chk("d2_b0_hand", int'(rd_data), 8'h02);
    read_all(2, "d2");

    // D=17 reference capture
    step(1, 0, 0, 0, 17, 0);
    chk("ref_rst_full", int'(wr_full), 0);
    for (int v = 234; v <= 279; v++) begin
      step(0, 1, v, 0, 17, 1);
      chk_cap("ref_pre");
    end
    step(0, 1, 289, 1, 17, 0);
    chk_cap("ref_trig");
    for (int v = 234; v <= 333; v++) begin
      step(0, 1, v, (v == 300 || v == 320), 17, 0);
      chk_cap("ref_post");
      if (v == 314) chk("ref_nfull314", int'(wr_full), 0);
      if (v == 315) chk("ref_full315", int'(wr_full), 1);
    end
    chk("ref_b0_hand", int'(rd_data), 8'h41);
    step(0, 0, 0, 0, 17, 1);
    chk("ref_b1_hand", int'(rd_data), 8'hD0);
    step(1, 0, 0, 0, 17, 0);
    for (int v = 234; v <= 279; v++) step(0, 1, v, 0, 17, 0);
    step(0, 1, 289, 1, 17, 0);
    for (int v = 234; v <= 333; v++) step(0, 1, v, 0, 17, 0);
    read_all(17, "ref");

    // reset mid-POST, then D=0 capture triggered on first write
    step(1, 0, 0, 0, 5, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 900 + i, 0, 5, 0);
    step(0, 0, 0, 1, 5, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 950 + i, 0, 5, 0);
    step(1, 1, 1, 1, 5, 1);
    chk("mid_rst_full", int'(wr_full), 0);
    chk("mid_rst_rd", int'(rd_data), 0);
    for (int i = 0; i < 100; i++) begin
      step(0, 1, 500 + i, (i == 0), 0, 0);
      chk_cap("d0_fill");
      if (i == 98) chk("d0_nfull99", int'(wr_full), 0);
    end
    chk("d0_full", int'(wr_full), 1);
    chk("d0_b0_hand", int'(rd_data), 8'h7D);
    read_all(0, "d0");

    // depth 1000 clamps to 99
    step(1, 0, 0, 0, 1000, 0);
    for (int i = 0; i < 120; i++) begin
      step(0, 1, (i * 7) & 1023, 0, 1000, 0);
      chk_cap("clamp_pre");
    end
    step(0, 1, 777, 1, 1000, 0);
    chk("clamp_full", int'(wr_full), 1);
    chk("clamp_b0_hand", int'(rd_data), 8'h24);
    for (int k = 1; k < 10; k++) begin
      step(0, 0, 0, 0, 1000, 1);
      chk("clamp_byte", int'(rd_data), int'(exp_byte(k)));
    end
    step(1, 0, 0, 0, 1000, 1);
    chk("rd_rst_full", int'(wr_full), 0);
    chk("rd_rst_rd", int'(rd_data), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
